operand_fetch_stage: RTL

ID/EX boundary stage that sits directly upstream of the 16x32 register file. It drives the file's two read addresses and captures the returned operands. It resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards, which insert a one-cycle bubble. It registers the resolved operands plus control into the EX pipeline register with a valid/ready stall handshake and a flush.

---
 rtl/operand_fetch_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_stage
//  Description : ID/EX boundary stage. Drives the register file read
//                addresses, resolves RAW hazards by forwarding from EX, MEM
//                and WB (in that priority), detects load-use hazards and
//                inserts a one-cycle bubble, and registers the resolved
//                operands plus control into the EX pipeline register with a
//                valid/ready stall handshake and a flush.
//  Optional    : `define OF_PERF_CNT_EN to enable the saturating load-use
//                stall counter on stall_count (otherwise it is tied to 0).
//  Ports       : clk/reset            - clock, async active-high reset
//                id_*                 - decoded instruction from ID
//                rf_op1/rf_op2        - register file read addresses (comb)
//                rf_rdData1/2         - register file read data (comb)
//                ex_*/mem_*/wb_*      - forwarding sources in later stages
//                ex_ready, flush      - EX back-pressure, pipeline kill
//                stall_out            - hold IF/ID this cycle (comb)
//                of_*                 - EX pipeline register outputs
//                stall_count          - load-use bubble counter
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [REG_AW-1:0] rf_op1,
    output logic [REG_AW-1:0] rf_op2,
    input  logic [DATA_W-1:0] rf_rdData1,
    input  logic [DATA_W-1:0] rf_rdData2,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              ex_wr_en,
    input  logic              mem_wr_en,
    input  logic              wb_wr_en,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              stall_out,
    output logic              of_valid,
    output logic [DATA_W-1:0] of_a,
    output logic [DATA_W-1:0] of_b,
    output logic [REG_AW-1:0] of_dst,
    output logic              of_wr_en,
    output logic              of_is_load,
    output logic [CTRL_W-1:0] of_ctrl,
    output logic [31:0]       stall_count
);

    // Registers 14 and 15 are write-protected: they never forward and never
    // create hazards, so sources naming them always read the file directly.
    localparam logic [REG_AW-1:0] PROT_BASE = REG_AW'(14);

    assign rf_op1 = id_src1;
    assign rf_op2 = id_src2;

    logic prot1, prot2;
    assign prot1 = (id_src1 >= PROT_BASE);
    assign prot2 = (id_src2 >= PROT_BASE);

    // A match requires an unprotected source; equal dst then cannot be
    // protected either, so the dst-side protection is implied.
    logic ex_hit1, mem_hit1, wb_hit1;
    logic ex_hit2, mem_hit2, wb_hit2;
    assign ex_hit1  = ex_wr_en  && (ex_dst  == id_src1) && !prot1;
    assign mem_hit1 = mem_wr_en && (mem_dst == id_src1) && !prot1;
    assign wb_hit1  = wb_wr_en  && (wb_dst  == id_src1) && !prot1;
    assign ex_hit2  = ex_wr_en  && (ex_dst  == id_src2) && !prot2;
    assign mem_hit2 = mem_wr_en && (mem_dst == id_src2) && !prot2;
    assign wb_hit2  = wb_wr_en  && (wb_dst  == id_src2) && !prot2;

    logic [DATA_W-1:0] opa, opb;
    always_comb begin
        opa = rf_rdData1;
        if (ex_hit1)       opa = ex_result;
        else if (mem_hit1) opa = mem_result;
        else if (wb_hit1)  opa = wb_data;

        opb = rf_rdData2;
        if (ex_hit2)       opb = ex_result;
        else if (mem_hit2) opb = mem_result;
        else if (wb_hit2)  opb = wb_data;
    end

    // A load in EX cannot forward yet; an instruction that really reads its
    // destination must wait one cycle and pick it up from MEM.
    logic hazard;
    assign hazard = id_valid && ex_is_load &&
                    ((id_use1 && ex_hit1) || (id_use2 && ex_hit2));

    logic valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic              wr_en_q, wr_en_d, is_load_q, is_load_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic hold, bubble;
    assign hold   = !flush && !ex_ready && valid_q;
    assign bubble = !flush && !hold && hazard;

    // Reset drives the state registers to zero, but hazard is purely
    // combinational from inputs, so gate it explicitly here.
    assign stall_out = !reset && (hold || bubble);

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        dst_d     = dst_q;
        wr_en_d   = wr_en_q;
        is_load_d = is_load_q;
        ctrl_d    = ctrl_q;
        if (flush || bubble) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            valid_d   = id_valid;
            a_d       = opa;
            b_d       = opb;
            dst_d     = id_dst;
            wr_en_d   = id_wr_en;
            is_load_d = id_is_load;
            ctrl_d    = id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            dst_q     <= '0;
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dst_q     <= dst_d;
            wr_en_q   <= wr_en_d;
            is_load_q <= is_load_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign of_valid   = valid_q;
    assign of_a       = a_q;
    assign of_b       = b_q;
    assign of_dst     = dst_q;
    assign of_wr_en   = wr_en_q;
    assign of_is_load = is_load_q;
    assign of_ctrl    = ctrl_q;

`ifdef OF_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end
    assign stall_count = cnt_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire
